// File: rtl/mod31_residue_checker.sv
// Mod-31 residue checker: folds a frame of 64-bit words (first beat most significant)
// into a canonical mod-31 residue and compares it against the transmitted residue.
module mod31_residue_checker #(
   parameter int MAX_BEATS = 256,
   parameter int CNT_W     = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   input  logic        in_last,
   input  logic [4:0]  in_residue,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [4:0]  res_residue,
   output logic        res_err,
   output logic        res_len_err
);

   localparam logic [0:0] ACCUM  = 1'b0;
   localparam logic [0:0] RESULT = 1'b1;

   logic [0:0]       state_reg;
   logic [4:0]       acc_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             len_err_reg;

   logic [12:0][4:0] field;
   logic [8:0]       field_sum;
   logic [5:0]       word_fold1;
   logic [5:0]       word_fold2;
   logic [4:0]       word_res;
   logic [4:0]       acc_rot;
   logic [5:0]       acc_sum;
   logic [5:0]       acc_fold;
   logic [4:0]       acc_next;
   logic [4:0]       residue_canon;
   logic             beat_ok;
   logic             overflow;

   // 2^5 = 1 mod 31, so each 5-bit slice contributes its plain value.
   genvar gi;
   generate
      for (gi = 0; gi < 12; gi++) begin : g_field
         assign field[gi] = in_data[5*gi +: 5];
      end
   endgenerate
   assign field[12] = {1'b0, in_data[63:60]};

   always_comb begin
      field_sum = '0;
      for (int i = 0; i < 13; i++) begin
         field_sum = field_sum + {4'd0, field[i]};
      end
   end

   // Two end-around folds bring the 9-bit sum into 0..31.
   assign word_fold1 = {1'b0, field_sum[4:0]} + {2'b00, field_sum[8:5]};
   assign word_fold2 = {1'b0, word_fold1[4:0]} + {5'd0, word_fold1[5]};
   assign word_res   = (word_fold2[4:0] == 5'd31) ? 5'd0 : word_fold2[4:0];

   // Shifting by 64 bits multiplies by 16 mod 31, i.e. a 5-bit rotate left by 4.
   assign acc_rot  = {acc_reg[0], acc_reg[4:1]};
   assign acc_sum  = {1'b0, acc_rot} + {1'b0, word_res};
   assign acc_fold = {1'b0, acc_sum[4:0]} + {5'd0, acc_sum[5]};
   assign acc_next = (acc_fold[4:0] == 5'd31) ? 5'd0 : acc_fold[4:0];

   assign residue_canon = (in_residue == 5'd31) ? 5'd0 : in_residue;
   assign in_ready      = (state_reg == ACCUM);
   assign beat_ok       = in_valid & in_ready;
   assign overflow      = (cnt_reg == CNT_W'(MAX_BEATS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ACCUM;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         len_err_reg <= 1'b0;
         res_valid   <= 1'b0;
         res_residue <= '0;
         res_err     <= 1'b0;
         res_len_err <= 1'b0;
      end else begin
         case (state_reg)
            ACCUM: begin
               if (beat_ok) begin
                  if (in_last) begin
                     res_residue <= acc_next;
                     res_err     <= (acc_next != residue_canon);
                     res_len_err <= len_err_reg | overflow;
                     res_valid   <= 1'b1;
                     acc_reg     <= '0;
                     cnt_reg     <= '0;
                     len_err_reg <= 1'b0;
                     state_reg   <= RESULT;
                  end else begin
                     acc_reg <= acc_next;
                     if (cnt_reg != CNT_W'(MAX_BEATS + 1)) begin
                        cnt_reg <= cnt_reg + 1'b1;
                     end
                     if (overflow) begin
                        len_err_reg <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state_reg <= ACCUM;
               end
            end
         endcase
      end
   end

endmodule
